// File: rtl/updown_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : updown_seq_decoder
// Purpose  : Watches a sampled count value, classifies each step against the
//            previous sample (UP / DOWN / HOLD / JUMP, modulo 2^WIDTH), and
//            locks onto a counting direction after LOCK_CNT consecutive
//            same-direction steps. While locked it reports reversals,
//            wrap-around steps and illegal jumps as one-cycle pulses.
// Options  : UPDOWN_SEQ_DECODER_WRAPCNT_EN -- when defined, wrap_cnt is a
//            saturating 8-bit count of wrap pulses; when undefined, wrap_cnt
//            is tied to zero and no counter register exists.
// Revision : 1.0 - initial release
// ============================================================================
module updown_seq_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  output logic             dir,
  output logic             locked,
  output logic             dir_change,
  output logic             wrap,
  output logic             err,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_zero     = '0;
  localparam logic [WIDTH-1:0] c_max      = '1;
  localparam logic [3:0]       c_lock_cnt = 4'(LOCK_CNT);

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [3:0]       run_q;
  logic             cand_q;
  logic             dir_q;
  logic             locked_q;
  logic             dir_change_q;
  logic             wrap_q;
  logic             err_q;

  // Step classification of the current sample against the previous one
  logic [WIDTH-1:0] w_prev_inc;
  logic [WIDTH-1:0] w_prev_dec;
  logic             w_up;
  logic             w_down;
  logic             w_step;
  logic             w_jump;
  logic             w_wrap_step;

  assign w_prev_inc  = prev_q + c_one;
  assign w_prev_dec  = prev_q - c_one;
  assign w_up        = (count_in == w_prev_inc);
  // UP takes precedence so a 1-bit count (where +1 == -1) still classifies
  assign w_down      = !w_up && (count_in == w_prev_dec);
  assign w_step      = w_up || w_down;
  assign w_jump      = !w_step && (count_in != prev_q);
  assign w_wrap_step = (w_up && (prev_q == c_max)) || (w_down && (prev_q == c_zero));

  // Acquisition run counter / candidate direction for the current sample
  logic [3:0] run_d;
  logic       cand_d;
  logic       w_lock_hit;

  always_comb begin
    run_d  = run_q;
    cand_d = cand_q;
    if (w_step) begin
      if (w_up == cand_q) begin
        run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
      end else begin
        run_d  = 4'd1;
        cand_d = w_up;
      end
    end else if (w_jump) begin
      run_d = 4'd0;
    end
  end

  assign w_lock_hit = (run_d == c_lock_cnt);

  // Main sequencer: state, history, direction tracking and pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      run_q        <= 4'd0;
      cand_q       <= 1'b1;
      dir_q        <= 1'b1;
      locked_q     <= 1'b0;
      dir_change_q <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      prev_q       <= count_in;
      dir_change_q <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // First sample after reset only seeds the history
          state_q <= ST_ACQ;
        end
        ST_ACQ: begin
          run_q  <= run_d;
          cand_q <= cand_d;
          if (w_lock_hit) begin
            state_q  <= ST_LOCK;
            locked_q <= 1'b1;
            dir_q    <= cand_d;
          end
        end
        ST_LOCK: begin
          if (w_jump) begin
            err_q    <= 1'b1;
            locked_q <= 1'b0;
            run_q    <= 4'd0;
            state_q  <= ST_ACQ;
          end else if (w_step) begin
            wrap_q <= w_wrap_step;
            if (w_up != dir_q) begin
              dir_q  <= w_up;
              cand_q <= w_up;
              // A reversal that also wraps reports only the wrap, keeping
              // the pulses mutually exclusive; dir still toggles.
              dir_change_q <= !w_wrap_step;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dir        = dir_q;
  assign locked     = locked_q;
  assign dir_change = dir_change_q;
  assign wrap       = wrap_q;
  assign err        = err_q;

`ifdef UPDOWN_SEQ_DECODER_WRAPCNT_EN
  logic [7:0] wrap_cnt_q;
  logic       w_wrap_fire;

  // Same condition that raises wrap_q, so the count updates with the pulse
  assign w_wrap_fire = (state_q == ST_LOCK) && w_wrap_step;

  // Saturating count of wrap pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_cnt_q <= 8'd0;
    end else if (w_wrap_fire && (wrap_cnt_q != 8'hFF)) begin
      wrap_cnt_q <= wrap_cnt_q + 8'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  assign wrap_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_updown_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_seq_decoder
// Purpose  : Directed self-checking bench for updown_seq_decoder
//            (WIDTH=4, LOCK_CNT=2). Expected wrap_cnt values follow the
//            UPDOWN_SEQ_DECODER_WRAPCNT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_seq_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       dir;
  logic       locked;
  logic       dir_change;
  logic       wrap;
  logic       err;
  logic [7:0] wrap_cnt;

  int checks;
  int errors;

`ifdef UPDOWN_SEQ_DECODER_WRAPCNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  updown_seq_decoder #(.WIDTH(4), .LOCK_CNT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .dir        (dir),
    .locked     (locked),
    .dir_change (dir_change),
    .wrap       (wrap),
    .err        (err),
    .wrap_cnt   (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one sample, clock it in, and settle just after the edge
  task automatic tick(input logic [3:0] v, input logic r);
    reset    = r;
    count_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(4'd7, 1'b1);
    tick(4'd9, 1'b1);
    checks++;
    if ({dir, locked, dir_change, wrap, err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got dir,locked,dc,wrap,err=%b expected 10000",
               {dir, locked, dir_change, wrap, err});
    end
    checks++;
    if (wrap_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_wrap_cnt: got %0d expected 0", wrap_cnt);
    end
  endtask

  task automatic test_lock_up();
    tick(4'd0, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_idle: got locked=%b expected 0", locked);
    end
    tick(4'd1, 1'b0);
    checks++;
    if (locked !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL lock_run1: got locked=%b err=%b expected 0 0", locked, err);
    end
    tick(4'd2, 1'b0);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL lock_hit: got locked=%b dir=%b err=%b expected 1 1 0", locked, dir, err);
    end
  endtask

  task automatic test_wrap_up();
    for (int v = 3; v <= 14; v++) begin
      tick(4'(v), 1'b0);
      checks++;
      if (locked !== 1'b1 || wrap !== 1'b0 || err !== 1'b0 || dir_change !== 1'b0) begin
        errors++;
        $display("FAIL wrapup_climb v=%0d: got locked=%b wrap=%b err=%b dc=%b expected 1 0 0 0",
                 v, locked, wrap, err, dir_change);
      end
    end
    tick(4'd14, 1'b0);  // hold while locked
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1 || {wrap, err, dir_change} !== 3'b000) begin
      errors++;
      $display("FAIL hold_locked: got locked=%b dir=%b pulses=%b expected 1 1 000",
               locked, dir, {wrap, err, dir_change});
    end
    tick(4'd15, 1'b0);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrapup_15: got wrap=%b expected 0", wrap);
    end
    tick(4'd0, 1'b0);
    checks++;
    if (wrap !== 1'b1 || dir_change !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL wrapup_pulse: got wrap=%b dc=%b err=%b expected 1 0 0", wrap, dir_change, err);
    end
    checks++;
    if (wrap_cnt !== (WC_EN ? 8'd1 : 8'd0)) begin
      errors++;
      $display("FAIL wrapup_cnt: got %0d expected %0d", wrap_cnt, WC_EN ? 1 : 0);
    end
    tick(4'd1, 1'b0);
    checks++;
    if (wrap !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL wrapup_after: got wrap=%b locked=%b expected 0 1", wrap, locked);
    end
  endtask

  task automatic test_dir_change();
    for (int v = 2; v <= 5; v++) tick(4'(v), 1'b0);
    tick(4'd4, 1'b0);
    checks++;
    if (dir_change !== 1'b1 || dir !== 1'b0 || locked !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL dirchg_pulse: got dc=%b dir=%b locked=%b wrap=%b expected 1 0 1 0",
               dir_change, dir, locked, wrap);
    end
    tick(4'd3, 1'b0);
    checks++;
    if (dir_change !== 1'b0 || dir !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL dirchg_after: got dc=%b dir=%b locked=%b expected 0 0 1", dir_change, dir, locked);
    end
  endtask

  task automatic test_wrap_down();
    tick(4'd2, 1'b0);
    tick(4'd1, 1'b0);
    tick(4'd0, 1'b0);
    checks++;
    if (wrap !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL wrapdn_at0: got wrap=%b dir=%b expected 0 0", wrap, dir);
    end
    tick(4'd15, 1'b0);
    checks++;
    if (wrap !== 1'b1 || dir !== 1'b0 || dir_change !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL wrapdn_pulse: got wrap=%b dir=%b dc=%b locked=%b expected 1 0 0 1",
               wrap, dir, dir_change, locked);
    end
    checks++;
    if (wrap_cnt !== (WC_EN ? 8'd2 : 8'd0)) begin
      errors++;
      $display("FAIL wrapdn_cnt: got %0d expected %0d", wrap_cnt, WC_EN ? 2 : 0);
    end
    tick(4'd14, 1'b0);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrapdn_after: got wrap=%b expected 0", wrap);
    end
  endtask

  task automatic test_err();
    tick(4'd0, 1'b1);
    tick(4'd4, 1'b0);
    tick(4'd5, 1'b0);
    tick(4'd6, 1'b0);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL err_prelock: got locked=%b dir=%b expected 1 1", locked, dir);
    end
    tick(4'd9, 1'b0);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || wrap !== 1'b0 || dir_change !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got err=%b locked=%b wrap=%b dc=%b expected 1 0 0 0",
               err, locked, wrap, dir_change);
    end
    tick(4'd10, 1'b0);
    checks++;
    if (err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL err_run1: got err=%b locked=%b expected 0 0", err, locked);
    end
    tick(4'd11, 1'b0);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_relock: got locked=%b dir=%b err=%b expected 1 1 0", locked, dir, err);
    end
  endtask

  task automatic test_reset_mid_lock();
    tick(4'd0, 1'b1);
    tick(4'd1, 1'b0);
    tick(4'd2, 1'b0);
    tick(4'd3, 1'b0);
    tick(4'd0, 1'b0);  // wrap-free check point not needed; re-establish 3
    tick(4'd1, 1'b0);
    tick(4'd2, 1'b0);
    tick(4'd3, 1'b0);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL rst_prelock: got locked=%b dir=%b expected 1 1", locked, dir);
    end
    tick(4'd12, 1'b1);
    checks++;
    if ({dir, locked, dir_change, wrap, err} !== 5'b10000 || wrap_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_midlock: got dir,locked,dc,wrap,err=%b wrap_cnt=%0d expected 10000 0",
               {dir, locked, dir_change, wrap, err}, wrap_cnt);
    end
    // IDLE only seeds history, so 1 is not counted as a step from 0
    tick(4'd1, 1'b0);
    tick(4'd2, 1'b0);
    checks++;
    if (locked !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_seed: got locked=%b err=%b expected 0 0", locked, err);
    end
    tick(4'd3, 1'b0);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL rst_relock: got locked=%b dir=%b expected 1 1", locked, dir);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    count_in = 4'd0;
    test_reset();
    test_lock_up();
    test_wrap_up();
    test_dir_change();
    test_wrap_down();
    test_err();
    test_reset_mid_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
